// File: rtl/mem_if_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package    : mem_if_pkg                                            |
// | Description: Load/store interface encodings shared between the CPU |
// |              memory controller and the data-memory responder.      |
// | Revision   : 1.0                                                   |
// +--------------------------------------------------------------------+
package mem_if_pkg;

  // RISC-V funct3 load/store size encodings
  localparam logic [2:0] MT_B  = 3'b000;
  localparam logic [2:0] MT_H  = 3'b001;
  localparam logic [2:0] MT_W  = 3'b010;
  localparam logic [2:0] MT_BU = 3'b100;
  localparam logic [2:0] MT_HU = 3'b101;

  // Sticky fault flag bit positions
  localparam int ERR_MISALIGN = 0;
  localparam int ERR_RANGE    = 1;
  localparam int ERR_CONFLICT = 2;
  localparam int ERR_W        = 3;

  // Access size decoded from funct3; SZ_BAD covers 011, 110 and 111
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } mem_size_e;

  // Signedness (bit 2) does not affect the access width; 11x is illegal
  function automatic mem_size_e decode_size(input logic [2:0] mem_type);
    if (mem_type[2] && mem_type[1]) begin
      return SZ_BAD;
    end
    return mem_size_e'(mem_type[1:0]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_steer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module     : mem_lane_steer                                        |
// | Description: Combinational byte-lane steering: byte enables, store |
// |              data replication, alignment check, load extraction.  |
// | Revision   : 1.0                                                   |
// +--------------------------------------------------------------------+
module mem_lane_steer
  import mem_if_pkg::*;
(
  input  logic [2:0]  mem_type,
  input  logic [1:0]  lane,
  input  logic [31:0] wr_data,
  input  logic [31:0] rd_word,
  output logic [3:0]  byte_en,
  output logic [31:0] wr_word,
  output logic        misalign,
  output logic [31:0] rd_data
);

  // Size-dependent lane selection; illegal sizes enable no lanes
  always_comb begin
    byte_en  = 4'b0000;
    wr_word  = wr_data;
    misalign = 1'b0;
    rd_data  = 32'h0;
    case (decode_size(mem_type))
      SZ_BYTE: begin
        byte_en = 4'b0001 << lane;
        wr_word = {4{wr_data[7:0]}};
        rd_data = {24'h0, rd_word[8*lane +: 8]};
      end
      SZ_HALF: begin
        misalign = lane[0];
        byte_en  = lane[1] ? 4'b1100 : 4'b0011;
        wr_word  = {2{wr_data[15:0]}};
        rd_data  = {16'h0, rd_word[16*lane[1] +: 16]};
      end
      SZ_WORD: begin
        misalign = |lane;
        byte_en  = 4'b1111;
        rd_data  = rd_word;
      end
      default: begin
        misalign = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module     : data_mem_responder                                    |
// | Description: Data memory with zero-latency reads, byte-lane writes,|
// |              sticky fault status and saturating access counters.   |
// | Revision   : 1.0                                                   |
// +--------------------------------------------------------------------+
module data_mem_responder
  import mem_if_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [31:0]      MEM_addr,
  input  logic [31:0]      MEM_WR_out,
  input  logic [2:0]       MEM_type,
  input  logic             MEM_rd_en,
  input  logic             MEM_wr_en,
  input  logic             ERR_clr,
  output logic [31:0]      MEM_data,
  output logic [ERR_W-1:0] ERR_flags,
  output logic [31:0]      ERR_addr,
  output logic [CNT_W-1:0] RD_count,
  output logic [CNT_W-1:0] WR_count
);

  localparam int          IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) << 2;

  logic [31:0]      mem [DEPTH_WORDS];

  logic [31:0]      offset;
  logic             in_range;
  logic [IDX_W-1:0] widx;
  logic [31:0]      rd_word;
  logic [3:0]       byte_en;
  logic [31:0]      wr_word;
  logic             misalign;
  logic [31:0]      rd_extract;
  logic             any_req;
  logic             both_req;
  logic             access_ok;
  logic             rd_valid;
  logic             wr_valid;
  logic             mem_we;
  logic [ERR_W-1:0] fault;

  assign offset   = MEM_addr - BASE_ADDR;
  assign in_range = {1'b0, offset} < SPAN_BYTES;
  assign widx     = offset[IDX_W+1:2];
  assign rd_word  = mem[widx];

  mem_lane_steer u_steer (
    .mem_type (MEM_type),
    .lane     (MEM_addr[1:0]),
    .wr_data  (MEM_WR_out),
    .rd_word  (rd_word),
    .byte_en  (byte_en),
    .wr_word  (wr_word),
    .misalign (misalign),
    .rd_data  (rd_extract)
  );

  assign any_req   = MEM_rd_en | MEM_wr_en;
  assign both_req  = MEM_rd_en & MEM_wr_en;
  assign access_ok = any_req & ~both_req & in_range & ~misalign;
  assign rd_valid  = access_ok & MEM_rd_en;
  assign wr_valid  = access_ok & MEM_wr_en;
  // Reset held across an edge must suppress the array write
  assign mem_we    = wr_valid & ~Reset;

  // Fault classification for this cycle; all zero when idle
  always_comb begin
    fault               = '0;
    fault[ERR_CONFLICT] = both_req;
    fault[ERR_RANGE]    = any_req & ~in_range;
    fault[ERR_MISALIGN] = any_req & misalign;
  end

  // Load data is combinational and forced to zero during reset
  assign MEM_data = (rd_valid && !Reset) ? rd_extract : 32'h0;

  // Storage array: byte-masked write, intentionally not reset
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem[widx][8*b +: 8] <= wr_word[8*b +: 8];
        end
      end
    end
  end

  // Sticky fault flags with first-fault address capture; clear has priority
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      ERR_flags <= '0;
      ERR_addr  <= 32'h0;
    end else if (ERR_clr) begin
      ERR_flags <= '0;
      ERR_addr  <= 32'h0;
    end else begin
      if ((|fault) && (ERR_flags == '0)) begin
        ERR_addr <= MEM_addr;
      end
      ERR_flags <= ERR_flags | fault;
    end
  end

  // Saturating counters of completed (non-faulting) accesses
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      RD_count <= '0;
      WR_count <= '0;
    end else begin
      if (rd_valid && (RD_count != '1)) begin
        RD_count <= RD_count + 1'b1;
      end
      if (wr_valid && (WR_count != '1)) begin
        WR_count <= WR_count + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module     : tb_data_mem_responder                                 |
// | Description: Directed vector table, reset corner cases and random  |
// |              traffic against a byte-addressed reference model.     |
// | Revision   : 1.0                                                   |
// +--------------------------------------------------------------------+
module tb_data_mem_responder;
  import mem_if_pkg::*;

  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          SPAN  = DEPTH * 4;

  logic        CLK;
  logic        Reset;
  logic [31:0] MEM_addr;
  logic [31:0] MEM_WR_out;
  logic [2:0]  MEM_type;
  logic        MEM_rd_en;
  logic        MEM_wr_en;
  logic        ERR_clr;

  logic [31:0] data_a, eaddr_a, data_b, eaddr_b;
  logic [2:0]  flags_a, flags_b;
  logic [15:0] rdc_a, wrc_a;
  logic [1:0]  rdc_b, wrc_b;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .CNT_W(16)) dut_a (
    .CLK(CLK), .Reset(Reset), .MEM_addr(MEM_addr), .MEM_WR_out(MEM_WR_out),
    .MEM_type(MEM_type), .MEM_rd_en(MEM_rd_en), .MEM_wr_en(MEM_wr_en), .ERR_clr(ERR_clr),
    .MEM_data(data_a), .ERR_flags(flags_a), .ERR_addr(eaddr_a),
    .RD_count(rdc_a), .WR_count(wrc_a)
  );

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .CNT_W(2)) dut_b (
    .CLK(CLK), .Reset(Reset), .MEM_addr(MEM_addr), .MEM_WR_out(MEM_WR_out),
    .MEM_type(MEM_type), .MEM_rd_en(MEM_rd_en), .MEM_wr_en(MEM_wr_en), .ERR_clr(ERR_clr),
    .MEM_data(data_b), .ERR_flags(flags_b), .ERR_addr(eaddr_b),
    .RD_count(rdc_b), .WR_count(wrc_b)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: byte-addressed memory plus status
  logic [7:0]  mb [SPAN];
  logic [2:0]  m_flags;
  logic [31:0] m_eaddr;
  int          m_rd;
  int          m_wr;

  typedef struct {
    logic        rd, wr, clr;
    logic [2:0]  t;
    logic [31:0] a, d;
    logic [31:0] x_data;
    logic [2:0]  x_flags;
    logic [31:0] x_eaddr;
    int          x_rd, x_wr;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%08h required=%08h", nm, act, exp);
    end
  endtask

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  function automatic int size_of(input logic [2:0] t);
    case (t)
      MT_B, MT_BU: return 1;
      MT_H, MT_HU: return 2;
      MT_W:        return 4;
      default:     return 0;
    endcase
  endfunction

  function automatic logic [2:0] m_faults(input logic rd, input logic wr,
                                          input logic [2:0] t, input logic [31:0] a);
    logic [31:0] off;
    int          sz;
    logic [2:0]  f;
    off = a - BASE;
    sz  = size_of(t);
    f   = 3'b000;
    if (rd || wr) begin
      f[2] = rd && wr;
      f[1] = off >= 32'(SPAN);
      f[0] = (sz == 0) ? 1'b1 : ((off % 32'(sz)) != 0);
    end
    return f;
  endfunction

  function automatic logic [31:0] m_rdata(input logic rd, input logic wr,
                                          input logic [2:0] t, input logic [31:0] a);
    logic [31:0] d;
    int          off;
    d = 32'h0;
    if (!rd || (m_faults(rd, wr, t, a) != 3'b000)) return d;
    off = int'(a - BASE);
    for (int i = 0; i < size_of(t); i++) d[8*i +: 8] = mb[off + i];
    return d;
  endfunction

  // Advance the model by one rising edge using the currently driven inputs
  task automatic m_edge();
    logic [2:0] f;
    int         off;
    if (Reset) begin
      m_flags = 3'b000; m_eaddr = 32'h0; m_rd = 0; m_wr = 0;
      return;
    end
    f = m_faults(MEM_rd_en, MEM_wr_en, MEM_type, MEM_addr);
    if (ERR_clr) begin
      m_flags = 3'b000; m_eaddr = 32'h0;
    end else begin
      if ((f != 3'b000) && (m_flags == 3'b000)) m_eaddr = MEM_addr;
      m_flags = m_flags | f;
    end
    if ((MEM_rd_en || MEM_wr_en) && (f == 3'b000)) begin
      if (MEM_rd_en) begin
        m_rd++;
      end else begin
        off = int'(MEM_addr - BASE);
        for (int i = 0; i < size_of(MEM_type); i++) mb[off + i] = MEM_WR_out[8*i +: 8];
        m_wr++;
      end
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic clr,
                       input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
    @(negedge CLK);
    MEM_rd_en = rd; MEM_wr_en = wr; ERR_clr = clr;
    MEM_type = t; MEM_addr = a; MEM_WR_out = d;
    #1;
  endtask

  task automatic tick();
    @(posedge CLK);
    m_edge();
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " flags"},  {29'h0, flags_a}, {29'h0, m_flags});
    chk({tag, " eaddr"},  eaddr_a, m_eaddr);
    chk({tag, " rdcnt"},  {16'h0, rdc_a}, 32'(sat(m_rd, 65535)));
    chk({tag, " wrcnt"},  {16'h0, wrc_a}, 32'(sat(m_wr, 65535)));
    chk({tag, " rdcnt2"}, {30'h0, rdc_b}, 32'(sat(m_rd, 3)));
    chk({tag, " wrcnt2"}, {30'h0, wrc_b}, 32'(sat(m_wr, 3)));
  endtask

  task automatic add(input logic rd, input logic wr, input logic clr, input logic [2:0] t,
                     input logic [31:0] a, input logic [31:0] d, input logic [31:0] xd,
                     input logic [2:0] xf, input logic [31:0] xe, input int xr, input int xw);
    vec_t v;
    v.rd = rd; v.wr = wr; v.clr = clr; v.t = t; v.a = a; v.d = d;
    v.x_data = xd; v.x_flags = xf; v.x_eaddr = xe; v.x_rd = xr; v.x_wr = xw;
    tv.push_back(v);
  endtask

  initial begin
    logic [2:0]  t;
    logic [31:0] a;
    logic        rd, wr, clr;
    int          sel, sz;

    Reset = 1'b1; MEM_addr = 32'h0; MEM_WR_out = 32'h0; MEM_type = MT_W;
    MEM_rd_en = 1'b0; MEM_wr_en = 1'b0; ERR_clr = 1'b0;
    m_flags = 3'b000; m_eaddr = 32'h0; m_rd = 0; m_wr = 0;

    //        rd wr clr type   addr    wdata         rdata         flags   eaddr  rd wr
    add(0, 1, 0, MT_W,  'h10,  'hDEADBEEF, 'h0,         3'b000, 'h0,   0, 1);
    add(1, 0, 0, MT_W,  'h10,  'h0,        'hDEADBEEF,  3'b000, 'h0,   1, 1);
    add(0, 1, 0, MT_W,  'h10,  'h11223344, 'h0,         3'b000, 'h0,   1, 2);
    add(0, 1, 0, MT_B,  'h13,  'h000000AA, 'h0,         3'b000, 'h0,   1, 3);
    add(1, 0, 0, MT_W,  'h10,  'h0,        'hAA223344,  3'b000, 'h0,   2, 3);
    add(1, 0, 0, MT_BU, 'h13,  'h0,        'h000000AA,  3'b000, 'h0,   3, 3);
    add(1, 0, 0, MT_HU, 'h12,  'h0,        'h0000AA22,  3'b000, 'h0,   4, 3);
    add(1, 0, 0, MT_B,  'h12,  'h0,        'h00000022,  3'b000, 'h0,   5, 3);
    add(1, 0, 0, MT_H,  'h12,  'h0,        'h0000AA22,  3'b000, 'h0,   6, 3);
    add(1, 0, 0, MT_H,  'h21,  'h0,        'h0,         3'b001, 'h21,  6, 3);
    add(0, 1, 0, MT_W,  'h22,  'hFFFFFFFF, 'h0,         3'b001, 'h21,  6, 3);
    add(1, 0, 0, MT_W,  'h10,  'h0,        'hAA223344,  3'b001, 'h21,  7, 3);
    add(0, 0, 1, MT_W,  'h0,   'h0,        'h0,         3'b000, 'h0,   7, 3);
    add(0, 1, 0, MT_W,  'h100, 'h12345678, 'h0,         3'b010, 'h100, 7, 3);
    add(0, 0, 1, MT_W,  'h0,   'h0,        'h0,         3'b000, 'h0,   7, 3);
    add(1, 1, 0, MT_W,  'h10,  'h55555555, 'h0,         3'b100, 'h10,  7, 3);
    add(1, 0, 0, MT_W,  'h10,  'h0,        'hAA223344,  3'b100, 'h10,  8, 3);
    add(0, 0, 1, MT_W,  'h0,   'h0,        'h0,         3'b000, 'h0,   8, 3);
    add(0, 1, 0, MT_W,  'h14,  'h0,        'h0,         3'b000, 'h0,   8, 4);
    add(0, 1, 0, MT_H,  'h16,  'h1234BEEF, 'h0,         3'b000, 'h0,   8, 5);
    add(1, 0, 0, MT_W,  'h14,  'h0,        'hBEEF0000,  3'b000, 'h0,   9, 5);
    add(1, 0, 0, 3'b011,'h10,  'h0,        'h0,         3'b001, 'h10,  9, 5);
    add(1, 0, 0, MT_HU, 'h16,  'h0,        'h0000BEEF,  3'b001, 'h10, 10, 5);
    add(0, 0, 1, MT_W,  'h0,   'h0,        'h0,         3'b000, 'h0,  10, 5);

    // Reset state, including zero load data while a read is requested
    repeat (2) @(posedge CLK);
    drive(1, 0, 0, MT_W, 32'h10, 32'h0);
    chk("reset data",   data_a, 32'h0);
    chk("reset flags",  {29'h0, flags_a}, 32'h0);
    chk("reset eaddr",  eaddr_a, 32'h0);
    chk("reset rdcnt",  {16'h0, rdc_a}, 32'h0);
    chk("reset wrcnt",  {16'h0, wrc_a}, 32'h0);
    chk("reset rdcnt2", {30'h0, rdc_b}, 32'h0);
    @(negedge CLK);
    Reset = 1'b0; MEM_rd_en = 1'b0;

    // Directed vector table
    foreach (tv[i]) begin
      drive(tv[i].rd, tv[i].wr, tv[i].clr, tv[i].t, tv[i].a, tv[i].d);
      chk($sformatf("vec%0d data", i), data_a, tv[i].x_data);
      tick();
      chk($sformatf("vec%0d flags", i),  {29'h0, flags_a}, {29'h0, tv[i].x_flags});
      chk($sformatf("vec%0d eaddr", i),  eaddr_a, tv[i].x_eaddr);
      chk($sformatf("vec%0d rdcnt", i),  {16'h0, rdc_a}, 32'(tv[i].x_rd));
      chk($sformatf("vec%0d wrcnt", i),  {16'h0, wrc_a}, 32'(tv[i].x_wr));
      chk($sformatf("vec%0d rdcnt2", i), {30'h0, rdc_b}, 32'(sat(tv[i].x_rd, 3)));
      chk($sformatf("vec%0d wrcnt2", i), {30'h0, wrc_b}, 32'(sat(tv[i].x_wr, 3)));
    end

    // Asynchronous reset mid-cycle clears status without a clock edge
    drive(1, 0, 0, MT_H, 32'h21, 32'h0);
    tick();
    chk("pre-reset flags", {29'h0, flags_a}, 32'h1);
    drive(1, 0, 0, MT_W, 32'h10, 32'h0);
    chk("pre-reset data", data_a, 32'hAA223344);
    #2 Reset = 1'b1;
    m_flags = 3'b000; m_eaddr = 32'h0; m_rd = 0; m_wr = 0;
    #1;
    chk("async data",   data_a, 32'h0);
    chk("async flags",  {29'h0, flags_a}, 32'h0);
    chk("async eaddr",  eaddr_a, 32'h0);
    chk("async rdcnt",  {16'h0, rdc_a}, 32'h0);
    chk("async wrcnt",  {16'h0, wrc_a}, 32'h0);
    chk("async rdcnt2", {30'h0, rdc_b}, 32'h0);

    // A store presented while reset is held across an edge is dropped
    drive(0, 1, 0, MT_W, 32'h10, 32'hCAFEF00D);
    tick();
    @(negedge CLK);
    Reset = 1'b0; MEM_wr_en = 1'b0;
    drive(1, 0, 0, MT_W, 32'h10, 32'h0);
    chk("reset-write data", data_a, 32'hAA223344);
    tick();
    chk_model("post-reset");

    // Fill the whole array so every later load has a known model value
    for (int w = 0; w < DEPTH; w++) begin
      drive(0, 1, 0, MT_W, BASE + 32'(w * 4), $urandom);
      tick();
      chk_model($sformatf("fill%0d", w));
    end

    // Random traffic against the reference model
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        t = 3'($urandom_range(0, 7));
      end else begin
        case ($urandom_range(0, 4))
          0:       t = MT_B;
          1:       t = MT_BU;
          2:       t = MT_H;
          3:       t = MT_HU;
          default: t = MT_W;
        endcase
      end
      sz = size_of(t);
      a  = BASE + 32'($urandom_range(0, SPAN - 1));
      if ((sz != 0) && ($urandom_range(0, 2) != 0)) a = a & ~32'(sz - 1);
      case ($urandom_range(0, 11))
        0: a = BASE + 32'(SPAN) + 32'($urandom_range(0, 63));
        1: a = 32'hFFFF_FFFC;
        default: ;
      endcase
      sel = $urandom_range(0, 15);
      rd  = (sel == 0) || ((sel >= 3) && (sel <= 8));
      wr  = (sel == 0) || (sel >= 9);
      clr = ($urandom_range(0, 19) == 0);
      if (clr) begin
        rd = 1'b0; wr = 1'b0;
      end
      drive(rd, wr, clr, t, a, $urandom);
      chk($sformatf("rnd%0d data", n), data_a, m_rdata(rd, wr, t, a));
      tick();
      chk_model($sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Data-memory responder at the far end of the CPU load/store interface. It accepts MEM_addr, MEM_WR_out, MEM_type, MEM_rd_en and MEM_wr_en, and returns MEM_data.
- Reads are combinational, so data is valid in the same cycle, as the non-stalling pipeline's stage 3 requires.
- Writes commit on the rising CLK edge, with byte-lane steering.
- It also keeps sticky fault status, fault-address capture and access counters for debug and the testbench.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array; must be a power of 2.
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be DEPTH_WORDS*4 aligned.
CNT_W, 16, width of the read and write counters.

Ports:
CLK  input  1  clock; rising-edge.
Reset  input  1  asynchronous, active-high reset.
MEM_addr  input  32  byte address from CPU stage 3.
MEM_WR_out  input  32  store data, LSB-aligned (byte in [7:0], half in [15:0]).
MEM_type  input  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
MEM_rd_en  input  1  load request this cycle.
MEM_wr_en  input  1  store request this cycle.
ERR_clr  input  1  synchronous clear of ERR_flags and ERR_addr.
MEM_data  output  32  addressed datum shifted to bit 0, upper bits zero; the CPU performs sign extension.
ERR_flags  output  3  sticky faults: [0] misaligned, [1] out-of-range, [2] rd_en and wr_en both high.
ERR_addr  output  32  MEM_addr of the first fault since the last clear.
RD_count  output  CNT_W  completed reads, saturating.
WR_count  output  CNT_W  completed writes, saturating.

Behaviour:
- Reset (asynchronous, active-high):
  - ERR_flags=0, ERR_addr=0, RD_count=0, WR_count=0.
  - The storage array is NOT reset; its contents are undefined until written.
  - MEM_data is 0 while Reset is high.
- Decode:
  - offset = MEM_addr - BASE_ADDR.
  - in_range = offset < DEPTH_WORDS*4.
  - widx = offset[log2(DEPTH_WORDS)+1:2].
  - lane = MEM_addr[1:0].
- Size:
  - MEM_type[1:0] 00 = byte, 01 = half, 10 = word.
  - 11, or MEM_type 110/111, is illegal and is treated as misaligned.
- Alignment:
  - half requires lane[0]=0; word requires lane=00.
  - Any violation is a misalign fault.
- Valid access: exactly one of rd_en/wr_en is high, the address is in range, and it is aligned.
- Read, combinational, zero latency:
  - valid read, byte: MEM_data = {24'b0, word[8*lane +: 8]}.
  - valid read, half: MEM_data = {16'b0, word[16*lane[1] +: 16]}.
  - valid read, word: MEM_data = full word.
  - invalid read or MEM_rd_en=0: MEM_data = 32'h0.
  - Read-during-write to the same word cannot occur in a valid cycle (the enables are exclusive).
- Write, at the rising CLK edge:
  - A valid write updates only the byte lanes selected by size and lane.
  - The data source is MEM_WR_out low bits replicated into the lane: byte -> {4{d[7:0]}}, half -> {2{d[15:0]}}; lanes are masked by byte-enable.
  - The new data is visible to combinational reads from the next cycle.
- Faults, evaluated only when rd_en|wr_en:
  - Both enables high sets ERR_flags[2]; no write and no read data (MEM_data=0).
  - Out-of-range sets [1]. Misaligned sets [0]. Multiple bits may set in one cycle.
  - A faulting write does not modify the array.
  - ERR_addr loads MEM_addr only when ERR_flags==0 and a fault occurs (first fault is captured).
- ERR_clr:
  - At the edge, clears ERR_flags and ERR_addr.
  - If a fault occurs in the same cycle, the clear wins and the new fault is lost.
  - The bench must not rely on that fault being captured.
- Counters:
  - RD_count increments on a valid read cycle; WR_count increments on a valid write.
  - Faulting accesses are not counted.
  - Both saturate at all-ones and are cleared only by Reset.
- Reset asserted mid-write (Reset high at an edge): no array write.

Decomposition:
- Shared package mem_if_pkg holds the following, shared with the CPU's MemControler:
  - MEM_type constants: MT_B=3'b000, MT_H=3'b001, MT_W=3'b010, MT_BU=3'b100, MT_HU=3'b101.
  - ERR bit index constants.
- One sub-module, mem_lane_steer (combinational): MEM_type, lane and store data in; byte-enable[3:0], replicated write word, misalign, and read-extract mux out.
- Storage, counters and fault registers stay in the top module.

Test Plan:
1. Reset; SW addr 0x10, data 0xDEADBEEF; then LW 0x10 -> same-cycle MEM_data=0xDEADBEEF; WR_count=1, RD_count=1.
2. SB 0x13 data 0x000000AA over word 0x11223344; LW 0x10 -> 0xAA223344; LBU 0x13 -> 0x000000AA; LHU 0x12 -> 0x0000AA22.
3. LH addr 0x21 -> MEM_data=0, ERR_flags=3'b001, ERR_addr=0x21, RD_count unchanged; then SW 0x22 -> flags stay 001, ERR_addr stays 0x21, array unchanged.
4. SW addr BASE+DEPTH_WORDS*4 -> ERR_flags[1]=1, no write; ERR_clr pulse -> ERR_flags=0, ERR_addr=0.
5. MEM_rd_en=MEM_wr_en=1 at addr 0x10 -> ERR_flags[2]=1, MEM_data=0, word 0x10 unchanged.
6. With CNT_W forced to 2: four valid reads -> RD_count=3 (saturated); assert Reset asynchronously mid-cycle -> all counters and flags 0 immediately, without waiting for a clock edge.
